// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, button indices and debounce default for the keypad front end
package keypad_pkg;

  localparam int BTN_NUM = 4;

  localparam int BTN_T = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;

  localparam logic [1:0] KEY_T = 2'd0;
  localparam logic [1:0] KEY_D = 2'd1;
  localparam logic [1:0] KEY_L = 2'd2;
  localparam logic [1:0] KEY_R = 2'd3;

  // 5 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  function automatic logic [1:0] lowest_key(input logic [BTN_NUM-1:0] v);
    if (v[BTN_T]) return KEY_T;
    if (v[BTN_D]) return KEY_D;
    if (v[BTN_L]) return KEY_L;
    return KEY_R;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: 2-flop synchroniser, hold counter and accepted stable level
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = |cnt;

endmodule

// File: rtl/keypad_event_encoder.sv
// rtl/keypad_event_encoder.sv - debounced T/D/L/R keypad to one-cycle key events with chord flag
// Optional KEYPAD_RELEASE_LOCK_EN: ignore further presses until every button is released.
module keypad_event_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_NUM-1:0] btn_raw,
  output logic [BTN_NUM-1:0] btn_level,
  output logic               key_valid,
  output logic [1:0]         key_code,
  output logic               key_multi,
  output logic               key_busy
);

  logic [BTN_NUM-1:0] stable;
  logic [BTN_NUM-1:0] stable_d;
  logic [BTN_NUM-1:0] busy_ch;
  logic [BTN_NUM-1:0] rise;
  logic               multi_now;
  logic               accept;

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(stable[i]),
      .busy (busy_ch[i])
    );
  end

  assign btn_level = stable;
  assign key_busy  = |busy_ch;
  assign rise      = stable & ~stable_d;

  // Chord: several simultaneous rises, or another button already held down.
  assign multi_now = ((rise & (rise - 4'd1)) != 4'd0) || ((stable & ~rise) != 4'd0);

`ifdef KEYPAD_RELEASE_LOCK_EN
  logic lock;

  assign accept = (|rise) && !lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock <= 1'b0;
    end else if (accept) begin
      lock <= 1'b1;
    end else if (stable == '0) begin
      lock <= 1'b0;
    end
  end
`else
  assign accept = |rise;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d  <= '0;
      key_valid <= 1'b0;
      key_code  <= KEY_T;
      key_multi <= 1'b0;
    end else begin
      stable_d  <= stable;
      key_valid <= accept;
      if (accept) begin
        key_code  <= lowest_key(rise);
        key_multi <= multi_now;
      end
    end
  end

endmodule

// File: doc/keypad_event_encoder.md
Name: keypad_event_encoder

Overview:
- Upstream front end for the four-button password FSM.
- Synchronises and debounces the raw T/D/L/R buttons and detects press edges.
- Produces a single registered one-cycle key event carrying a 2-bit key code and a chord/invalid flag.
- The downstream FSM advances on key_valid and treats key_multi=1 as a wrong entry.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronised level must hold before it is accepted (5 ms at 100 MHz); minimum 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- btn_raw  input  4  raw buttons; [0]=T, [1]=D, [2]=L, [3]=R; asynchronous, bouncy
- btn_level  output  4  debounced button levels
- key_valid  output  1  one-cycle key event strobe
- key_code  output  2  key code, valid with key_valid: 0=T, 1=D, 2=L, 3=R
- key_multi  output  1  valid with key_valid; 1 = chord or simultaneous press, entry invalid
- key_busy  output  1  1 while any debounce counter is non-zero

Behaviour:
- Reset (rst=1, clock-independent):
  - All sync flops, counters and stable levels go to 0.
  - All outputs go to 0.
- Per channel:
  - 2-flop synchroniser, then the debounce stage.
  - sync==stable: counter is cleared.
  - sync!=stable: counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, stable<=sync and the counter clears.
  - Any reversion to sync==stable before that point clears the counter; bounces shorter than DEBOUNCE_CYCLES produce nothing.
- Edge detect: rise[i] = stable[i] & ~stable_d[i], registered.
- Release (falling stable level) never produces an event.
- Event generation, in the cycle after any rise[i]=1:
  - key_valid=1 for exactly one cycle.
  - key_code = lowest index i with rise[i]=1.
  - key_multi=1 if more than one rise bit is set, or if any other channel's stable level is already 1 (chord); otherwise 0.
- key_code and key_multi hold their last values when key_valid=0.
- Latency: a clean edge on btn_raw sampled at cycle 0 gives key_valid at cycle DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 edge/output register).
- btn_level follows the stable levels directly, with no extra register.
- Button held through reset release: it debounces from 0 and produces a normal event. This is intended.
- Reset mid-debounce: the counter clears and no event is produced from the partial history.
- key_valid never asserts on two consecutive cycles for the same channel. Different channels may produce events on consecutive cycles.

Optional Feature:
- Macro: KEYPAD_RELEASE_LOCK_EN.
- Defined:
  - After any key_valid, a lock flag sets.
  - While locked, rise events are discarded entirely; no key_valid.
  - The lock clears in the cycle all four stable levels are 0, so the next press after a full release is accepted.
  - Reset clears the lock.
- Undefined:
  - No lock; every rise produces an event, with chord detection as specified above.

Decomposition:
- Shared package keypad_pkg holds:
  - Key code constants KEY_T=2'd0, KEY_D=2'd1, KEY_L=2'd2, KEY_R=2'd3.
  - Button index constants.
  - Default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce_ch: synchroniser, counter and stable level for one channel; instantiated 4×.
- Edge detect, encoder and lock logic live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Clean T press at cycle 0, held → key_valid=1 only at cycle 7; key_code=0, key_multi=0; btn_level=4'b0001 from cycle 6.
- L toggles 1,0,1,0 at 2-cycle intervals, then held high → no event during the bounce; one event with key_code=2 exactly 7 cycles after the final rising edge; release later produces no event.
- D and R rise in the same cycle → single key_valid with key_code=1, key_multi=1.
- T held stable, then R pressed:
  - Macro undefined: event key_code=3, key_multi=1.
  - Macro defined: no second event.
  - Macro defined, after all released and T re-pressed: event key_code=0.
- rst asserted for one cycle at cycle 4 of a T debounce → no key_valid; outputs 0 during reset; T still held after release → event at cycle 7 after rst deassert.
- Full password sequence T,L,L,R with releases between → four events with codes 0,2,2,3, all key_multi=0.
